prog_delay_line: RTL and testbench
==================================

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 12, signed sample width per channel.
REQ-002 SHALL have parameter CHANNELS, default 3, number of lanes delayed in lockstep.
REQ-003 SHALL have parameter MAX_DELAY, default 1024, power of two; maximum delay in strobes.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, sample strobe; one sample per lane accepted per high cycle.
REQ-007 SHALL have port data_in, input, CHANNELS*DATA_W, packed signed samples, lane 0 in the LSBs.
REQ-008 SHALL have port delay_sel, input, $clog2(MAX_DELAY)+1, requested delay in strobes.
REQ-009 SHALL have port data_out, output, CHANNELS*DATA_W, delayed samples in the same packing as data_in.
REQ-010 SHALL have port out_valid, output, 1, data_out updated this cycle.
REQ-011 SHALL have port primed, output, 1, buffer holds a full delay of history.

Function
REQ-012 SHALL measure delay in en strobes, not clock cycles; idle cycles (en=0) SHALL neither advance pointers nor alter outputs.
REQ-013 SHALL store samples in a circular buffer of MAX_DELAY entries, CHANNELS*DATA_W wide, with an ADDR_W-bit write pointer that wraps modulo MAX_DELAY.
REQ-014 On each en cycle, SHALL write data_in at wr_ptr, read address wr_ptr - D (modulo MAX_DELAY), and increment wr_ptr, where D is the effective delay.
REQ-015 SHALL register data_out and set out_valid high exactly one cycle after each en cycle; out_valid SHALL be low otherwise.
REQ-016 Read-during-write to the same address (D = MAX_DELAY) SHALL return the old contents (read-first).
REQ-017 Effective delay SHALL be clamped: a delay_sel of 0 gives D=1, and any delay_sel above MAX_DELAY gives D=MAX_DELAY.
REQ-018 delay_sel SHALL be sampled only on en cycles; the sampled value SHALL be held in a register D_reg.
REQ-019 SHALL implement a two-state FSM: FILL and RUN.
REQ-020 In FILL, a fill counter SHALL increment on each en; on the en that brings the count to D_reg, the FSM SHALL go to RUN.
REQ-021 Outputs produced from en cycles taken in FILL SHALL have data_out=0, with out_valid still pulsing.
REQ-022 primed SHALL equal (state==RUN), registered.
REQ-023 An en cycle whose clamped delay_sel differs from D_reg SHALL load D_reg, clear the fill counter, force FILL, and treat the current sample as the first fill sample; wr_ptr SHALL continue unaffected.
REQ-024 For D=1 with no delay change, SHALL enter RUN after the first en; the second en SHALL yield sample 1 on data_out.
REQ-025 All lanes SHALL share pointers and state; each lane's data SHALL be bit-exact, with no arithmetic applied.

Reset
REQ-026 rst SHALL clear asynchronously: wr_ptr=0, fill counter=0, state=FILL, D_reg=1, data_out=0, out_valid=0, primed=0.
REQ-027 Buffer contents SHALL NOT be reset; FILL masking SHALL guarantee that no stale data reaches data_out.
REQ-028 rst asserted mid-operation SHALL take effect immediately; the first en after release SHALL start a fresh FILL.

Structure
REQ-029 Package delay_pkg SHALL hold the state enum (FILL, RUN) and a clamp_delay function; ADDR_W SHALL derive from MAX_DELAY locally.
REQ-030 Storage SHALL be the sub-module delay_ram: simple dual-port, read-first, 1-cycle registered read, with no reset on the array, so that it infers block RAM.

Verification
REQ-031 Reset, then delay_sel=8 with en every cycle and lane0 = i*10 for i=0..19: data_out=0 for the first 8 outputs, then lane0 = 0, 10, 20, … in order; primed rises after the 8th en.
REQ-032 delay_sel=4, en high 1 cycle in 3, lane0 = 1, 2, 3, …: the 5th out_valid carries lane0=1; data_out holds between pulses.
REQ-033 delay_sel=MAX_DELAY with 2*MAX_DELAY+5 strobes: the output lags by exactly MAX_DELAY across the pointer wrap, and the read-first result is correct.
REQ-034 In RUN at delay 8, switch delay_sel to 3: primed drops, 3 zero outputs follow, then samples lag by 3.
REQ-035 delay_sel=0 and delay_sel=MAX_DELAY+7: these behave as delay 1 and delay MAX_DELAY respectively.
REQ-036 Pulse rst mid-stream in RUN: all outputs go to 0 asynchronously, and the next run reproduces the REQ-031 zero-fill pattern.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay line.
// Holds the fill/run state encoding and the delay clamp.
package delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Zero maps to one strobe; anything past the buffer depth saturates.
    function automatic logic [31:0] clamp_delay(
        input logic [31:0] sel,
        input logic [31:0] max_d
    );
        if (sel == 32'd0)
            return 32'd1;
        else if (sel > max_d)
            return max_d;
        else
            return sel;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample store, read-first, one-cycle registered read.
// The array and read register are left unreset so they map onto block RAM.
module delay_ram #(
    parameter int WIDTH  = 36,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane delay line whose delay is counted in sample strobes.
// Output is masked to zero until a full delay of history is stored.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CHANNELS  = 3,
    parameter int MAX_DELAY = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [CHANNELS*DATA_W-1:0]      data_in,
    input  logic [$clog2(MAX_DELAY):0]      delay_sel,
    output logic [CHANNELS*DATA_W-1:0]      data_out,
    output logic                            out_valid,
    output logic                            primed
);

    localparam int ADDR_W = $clog2(MAX_DELAY);
    localparam int SEL_W  = ADDR_W + 1;
    localparam int W      = CHANNELS * DATA_W;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [SEL_W-1:0]  d_reg;
    logic [SEL_W-1:0]  d_new;
    logic [SEL_W-1:0]  fill_cnt;
    logic [SEL_W-1:0]  fill_nxt;
    logic              change;
    logic              fill_mode;
    logic              zero_q;
    logic [W-1:0]      ram_q;
    state_t            state;

    assign d_new     = SEL_W'(clamp_delay(32'(delay_sel), 32'(MAX_DELAY)));
    assign change    = (d_new != d_reg);
    assign fill_mode = change || (state == FILL);
    assign fill_nxt  = change ? SEL_W'(1) : fill_cnt + SEL_W'(1);
    // D = MAX_DELAY wraps to wr_ptr itself; the RAM returns the old word.
    assign rd_addr   = wr_ptr - d_new[ADDR_W-1:0];

    delay_ram #(
        .WIDTH  (W),
        .ADDR_W (ADDR_W),
        .DEPTH  (MAX_DELAY)
    ) u_ram (
        .clk   (clk),
        .we    (en),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            d_reg     <= SEL_W'(1);
            state     <= FILL;
            primed    <= 1'b0;
            zero_q    <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                d_reg  <= d_new;
                zero_q <= fill_mode;
                if (fill_mode) begin
                    fill_cnt <= fill_nxt;
                    if (fill_nxt == d_new) begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end else begin
                        state  <= FILL;
                        primed <= 1'b0;
                    end
                end
            end
        end
    end

    // Buffer is never cleared, so anything read during fill is suppressed.
    assign data_out = zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line with directed strobe sequences.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_prog_delay_line;

    localparam int DATA_W    = 12;
    localparam int CHANNELS  = 3;
    localparam int MAX_DELAY = 1024;
    localparam int SEL_W     = $clog2(MAX_DELAY) + 1;
    localparam int W         = CHANNELS * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [W-1:0]     data_in;
    logic [SEL_W-1:0] delay_sel;
    logic [W-1:0]     data_out;
    logic             out_valid;
    logic             primed;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [W-1:0]     q [$];
    logic [W-1:0]     last_exp = '0;
    logic             hold_chk = 1'b0;

    prog_delay_line #(
        .DATA_W    (DATA_W),
        .CHANNELS  (CHANNELS),
        .MAX_DELAY (MAX_DELAY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .delay_sel (delay_sel),
        .data_out  (data_out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input int v);
        logic [DATA_W-1:0] l0;
        l0 = DATA_W'(v);
        return {l0 ^ 12'hA5A, ~l0, l0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    last_exp = q.pop_front();
                    chk("data_out", 64'(data_out), 64'(last_exp));
                end
            end else if (hold_chk) begin
                chk("hold", 64'(data_out), 64'(last_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the strobe and gap.
    task automatic strobe(input int sel, input int v,
                          input logic [W-1:0] exp, input int gap);
        en        = 1'b1;
        delay_sel = SEL_W'(sel);
        data_in   = mk(v);
        q.push_back(exp);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        #2;
        rst = 1'b1;
        q.delete();
        last_exp = '0;
        #1;
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_primed", 64'(primed), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic run_fill8();
        for (int i = 0; i < 20; i++) begin
            strobe(8, i * 10, (i < 8) ? '0 : mk((i - 8) * 10), 0);
            if (i == 6) chk("primed_7th", 64'(primed), 64'd0);
            if (i == 7) chk("primed_8th", 64'(primed), 64'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        data_in   = '0;
        delay_sel = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Delay 8 from reset
        run_fill8();

        // Switch from 8 to 3 while running
        for (int j = 0; j < 10; j++) begin
            strobe(3, 1000 + j, (j < 3) ? '0 : mk(1000 + j - 3), 0);
            if (j == 0) chk("primed_drop", 64'(primed), 64'd0);
            if (j == 2) chk("primed_d3", 64'(primed), 64'd1);
        end
        drain();

        // Delay 4 with en one cycle in three
        do_reset();
        hold_chk = 1'b1;
        for (int j = 0; j < 12; j++)
            strobe(4, 1 + j, (j < 4) ? '0 : mk(j - 3), 2);
        drain();
        hold_chk = 1'b0;

        // delay_sel = 0 acts as delay 1
        do_reset();
        for (int j = 0; j < 6; j++) begin
            strobe(0, 50 + j, (j < 1) ? '0 : mk(50 + j - 1), 0);
            if (j == 0) chk("primed_d1", 64'(primed), 64'd1);
        end
        drain();

        // Full depth across pointer wrap
        do_reset();
        for (int j = 0; j < 2 * MAX_DELAY + 5; j++) begin
            strobe(MAX_DELAY, j,
                   (j < MAX_DELAY) ? '0 : mk(j - MAX_DELAY), 0);
            if (j == MAX_DELAY - 2)
                chk("primed_max_m1", 64'(primed), 64'd0);
            if (j == MAX_DELAY - 1)
                chk("primed_max", 64'(primed), 64'd1);
        end
        // Over-range select clamps to the same delay: no refill
        for (int j = 2 * MAX_DELAY + 5; j < 2 * MAX_DELAY + 15; j++)
            strobe(MAX_DELAY + 7, j, mk(j - MAX_DELAY), 0);
        chk("primed_clamp", 64'(primed), 64'd1);
        drain();

        // Reset mid-stream then rerun the delay 8 pattern
        do_reset();
        for (int i = 0; i < 12; i++)
            strobe(8, i * 10, (i < 8) ? '0 : mk((i - 8) * 10), 0);
        do_reset();
        run_fill8();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
